// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
// FSM state encoding, default geometry and a counter-width helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        WAIT_RD   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int DEF_N      = 2;
    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;
    localparam int DEF_RD_LAT = 1;

    // A modulo-1 counter still needs one bit to exist.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/stall/done and memory-side strobe/data bundle.
// master = the controller (drives memory, answers the CPU); slave = CPU plus memory array.
interface mem_access_ctrl_if
    import mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic [DW/8-1:0]   cpu_be;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_stall;
    logic              cpu_done;

    logic              mem_tick;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic [DW-1:0]     mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
        output cpu_rdata, cpu_stall, cpu_done,
               mem_tick, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
        input  cpu_rdata, cpu_stall, cpu_done,
               mem_tick, mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_access_ctrl_tick_gen.sv
// Free-running phase counter 0..N-1; mem_tick is high for the last phase of each period.
// No handshake: the tick is a pure time base, one refclk cycle wide every N cycles.
module mem_tick_gen
    import mem_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic refclk,
    input  logic reset,
    output logic mem_tick
);

    localparam int            CW   = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] phase;

    always_ff @(posedge refclk) begin
        if (reset) begin
            phase <= '0;
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + CW'(1);
        end
    end

    assign mem_tick = (phase == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one CPU load/store at a time onto a memory clocked by an every-N-cycle enable.
// Store: 1 + cycles-to-next-tick + 1; loads add RD_LAT*N. CPU is stalled until cpu_done.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              refclk,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);

    localparam int             RCW      = $clog2(RD_LAT + 1);
    localparam logic [RCW-1:0] RD_LAT_C = RCW'(RD_LAT);

    state_t            state;
    logic              tick;
    logic              lat_we;
    logic [AW-1:0]     lat_addr;
    logic [DW-1:0]     lat_wdata;
    logic [DW/8-1:0]   lat_be;
    logic [RCW-1:0]    rd_cnt;
    logic [RCW-1:0]    rd_cnt_nxt;
    logic [DW-1:0]     rdata_q;

    mem_tick_gen #(
        .N (N)
    ) u_tick_gen (
        .refclk   (refclk),
        .reset    (reset),
        .mem_tick (tick)
    );

    assign rd_cnt_nxt = rd_cnt + RCW'(1);

    // The IDLE-cycle tick is deliberately skipped: the request is only latched at its end.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rd_cnt    <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        lat_we    <= bus.cpu_we;
                        lat_addr  <= bus.cpu_addr;
                        lat_wdata <= bus.cpu_wdata;
                        lat_be    <= bus.cpu_be;
                        state     <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (tick) begin
                        rd_cnt <= '0;
                        state  <= lat_we ? DONE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (tick) begin
                        rd_cnt <= rd_cnt_nxt;
                        if (rd_cnt_nxt == RD_LAT_C) begin
                            rdata_q <= bus.mem_rdata;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gating with reset keeps a stale WAIT_TICK from strobing memory in the reset cycle.
    assign bus.mem_tick  = tick;
    assign bus.mem_en    = (state == WAIT_TICK) && tick && !reset;
    assign bus.mem_we    = bus.mem_en && lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_be    = lat_be;

    assign bus.cpu_stall = ((state == IDLE) && bus.cpu_req) ||
                           (state == WAIT_TICK) || (state == WAIT_RD);
    assign bus.cpu_done  = (state == DONE);
    assign bus.cpu_rdata = rdata_q;

endmodule
